// File: rtl/neuron_seq_ctrl.sv
// Sequencer for a single binary neuron. It loads the threshold and weights from a
// serial config stream, then pairs each input beat with its stored weight word.
module neuron_seq_ctrl #(
    parameter int unsigned PW        = 16,
    parameter int unsigned THRESH_W  = 16,
    parameter int unsigned NUM_BEATS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_w_en,
    input  logic [PW-1:0]       cfg_w_data,
    input  logic                x_valid,
    input  logic [PW-1:0]       x_data,
    output logic                x_ready,
    output logic [PW-1:0]       n_x,
    output logic [PW-1:0]       n_w,
    output logic [THRESH_W-1:0] n_threshold,
    output logic                n_valid_in,
    output logic                n_last,
    output logic                configured,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int unsigned      IDX_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        ST_UNCFG   = 2'd0,
        ST_CFG_THR = 2'd1,
        ST_CFG_WGT = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    beat_idx_q, beat_idx_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [THRESH_W-1:0] thr_q, thr_d;
    logic [PW-1:0]       n_x_q, n_x_d;
    logic [PW-1:0]       n_w_q, n_w_d;
    logic                n_valid_q, n_valid_d;
    logic                n_last_q, n_last_d;
    logic                configured_q, configured_d;
    logic                cfg_done_q, cfg_done_d;
    logic                cfg_err_q, cfg_err_d;
    logic                wmem_we;

    logic [PW-1:0]       wmem [NUM_BEATS];

    // Weight storage carries no reset; it is always rewritten before RUN.
    always_ff @(posedge clk) begin
        if (wmem_we) begin
            wmem[wr_idx_q] <= cfg_w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNCFG;
            beat_idx_q   <= '0;
            wr_idx_q     <= '0;
            thr_q        <= '0;
            n_x_q        <= '0;
            n_w_q        <= '0;
            n_valid_q    <= 1'b0;
            n_last_q     <= 1'b0;
            configured_q <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            wr_idx_q     <= wr_idx_d;
            thr_q        <= thr_d;
            n_x_q        <= n_x_d;
            n_w_q        <= n_w_d;
            n_valid_q    <= n_valid_d;
            n_last_q     <= n_last_d;
            configured_q <= configured_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        wr_idx_d     = wr_idx_q;
        thr_d        = thr_q;
        n_x_d        = n_x_q;
        n_w_d        = n_w_q;
        n_valid_d    = 1'b0;
        n_last_d     = 1'b0;
        configured_d = configured_q;
        cfg_done_d   = 1'b0;
        cfg_err_d    = 1'b0;
        wmem_we      = 1'b0;
        x_ready      = 1'b0;

        unique case (state_q)
            ST_UNCFG: begin
                if (cfg_start) begin
                    state_d      = ST_CFG_THR;
                    wr_idx_d     = '0;
                    configured_d = 1'b0;
                end
            end
            ST_CFG_THR: begin
                if (cfg_start) begin
                    wr_idx_d = '0;
                end else if (cfg_w_en) begin
                    thr_d    = cfg_w_data[THRESH_W-1:0];
                    wr_idx_d = '0;
                    state_d  = ST_CFG_WGT;
                end
            end
            ST_CFG_WGT: begin
                if (cfg_start) begin
                    wr_idx_d = '0;
                    state_d  = ST_CFG_THR;
                end else if (cfg_w_en) begin
                    wmem_we  = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d     = '0;
                        cfg_done_d   = 1'b1;
                        configured_d = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Reconfiguration only at an image boundary; mid-image requests are flagged.
                x_ready = !(cfg_start && (beat_idx_q == '0));
                if (cfg_start) begin
                    if (beat_idx_q == '0) begin
                        state_d      = ST_CFG_THR;
                        wr_idx_d     = '0;
                        configured_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (x_valid && x_ready) begin
                    n_valid_d  = 1'b1;
                    n_x_d      = x_data;
                    n_w_d      = wmem[beat_idx_q];
                    n_last_d   = (beat_idx_q == LAST_IDX);
                    beat_idx_d = (beat_idx_q == LAST_IDX) ? '0 : beat_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_UNCFG;
            end
        endcase
    end

    assign n_x         = n_x_q;
    assign n_w         = n_w_q;
    assign n_threshold = thr_q;
    assign n_valid_in  = n_valid_q;
    assign n_last      = n_last_q;
    assign configured  = configured_q;
    assign cfg_done    = cfg_done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed bench for neuron_seq_ctrl: reset, config, streaming, gaps, reconfig rules
// and asynchronous reset.
module tb_neuron_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic        cfg_w_en;
    logic [15:0] cfg_w_data;
    logic        x_valid;
    logic [15:0] x_data;
    logic        x_ready;
    logic [15:0] n_x;
    logic [15:0] n_w;
    logic [15:0] n_threshold;
    logic        n_valid_in;
    logic        n_last;
    logic        configured;
    logic        cfg_done;
    logic        cfg_err;

    int vectors;
    int miscompares;
    int bidx;
    logic [15:0] wexp [4];

    neuron_seq_ctrl #(.PW(16), .THRESH_W(16), .NUM_BEATS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_w_en    (cfg_w_en),
        .cfg_w_data  (cfg_w_data),
        .x_valid     (x_valid),
        .x_data      (x_data),
        .x_ready     (x_ready),
        .n_x         (n_x),
        .n_w         (n_w),
        .n_threshold (n_threshold),
        .n_valid_in  (n_valid_in),
        .n_last      (n_last),
        .configured  (configured),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; registered outputs are sampled 2ns after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_word(input logic [15:0] d);
        cfg_w_en   = 1'b1;
        cfg_w_data = d;
        step();
        cfg_w_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_start = 1'b0; cfg_w_en = 1'b0; cfg_w_data = '0;
        x_valid = 1'b0; x_data = '0;
        step(); step();
        vectors++;
        if ({n_x, n_w, n_threshold, n_valid_in, n_last, configured, cfg_done, cfg_err, x_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got x=%h w=%h thr=%h v=%b l=%b cfgd=%b done=%b err=%b rdy=%b, want all 0",
                     n_x, n_w, n_threshold, n_valid_in, n_last, configured, cfg_done, cfg_err, x_ready);
        end
        rst = 1'b0;
        step();
        x_valid = 1'b1; x_data = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (x_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_x_ready[%0d]: got %b want 0", i, x_ready);
            end
            step();
            vectors++;
            if (n_valid_in !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_n_valid[%0d]: got %b want 0", i, n_valid_in);
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_config();
        wexp[0] = 16'hAAAA; wexp[1] = 16'h5555; wexp[2] = 16'hFFFF; wexp[3] = 16'h0000;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        write_word(16'd9);
        vectors++;
        if (n_threshold !== 16'd9) begin
            miscompares++;
            $display("FAIL cfg_threshold: got %h want 0009", n_threshold);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (x_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_x_ready[%0d]: got %b want 0", i, x_ready);
            end
            write_word(wexp[i]);
            vectors++;
            if ({cfg_done, configured} !== ((i == 3) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("FAIL cfg_done_configured[%0d]: got %b%b want %0d", i, cfg_done, configured, (i == 3) ? 11 : 0);
            end
        end
        #1;
        vectors++;
        if (x_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_run_x_ready: got %b want 1", x_ready);
        end
        step();
        vectors++;
        if ({cfg_done, configured} !== 2'b01) begin
            miscompares++;
            $display("FAIL cfg_done_one_cycle: got done=%b cfgd=%b want done=0 cfgd=1", cfg_done, configured);
        end
        bidx = 0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            x_valid = 1'b1;
            x_data  = 16'(16'h1111 * (k + 1));
            step();
            vectors++;
            if (n_valid_in !== 1'b1 || n_x !== 16'(16'h1111 * (k + 1)) || n_w !== wexp[bidx] || n_last !== (bidx == 3)) begin
                miscompares++;
                $display("FAIL b2b_beat[%0d]: got v=%b x=%h w=%h l=%b want v=1 x=%h w=%h l=%b",
                         k, n_valid_in, n_x, n_w, n_last, 16'(16'h1111 * (k + 1)), wexp[bidx], (bidx == 3));
            end
            bidx = (bidx + 1) % 4;
        end
        x_valid = 1'b0;
        step();
        vectors++;
        if (n_valid_in !== 1'b0 || n_last !== 1'b0 || n_x !== 16'h8888) begin
            miscompares++;
            $display("FAIL b2b_idle: got v=%b l=%b x=%h want v=0 l=0 x=8888", n_valid_in, n_last, n_x);
        end
    endtask

    task automatic test_gapped();
        for (int c = 0; c < 16; c++) begin
            x_valid = (c % 3 == 0);
            x_data  = 16'(16'hC000 + c);
            step();
            vectors++;
            if (c % 3 == 0) begin
                if (n_valid_in !== 1'b1 || n_x !== 16'(16'hC000 + c) || n_w !== wexp[bidx] || n_last !== (bidx == 3)) begin
                    miscompares++;
                    $display("FAIL gap_beat[%0d]: got v=%b x=%h w=%h l=%b want v=1 x=%h w=%h l=%b",
                             c, n_valid_in, n_x, n_w, n_last, 16'(16'hC000 + c), wexp[bidx], (bidx == 3));
                end
                bidx = (bidx + 1) % 4;
            end else if (n_valid_in !== 1'b0 || n_last !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_idle[%0d]: got v=%b l=%b want 0 0", c, n_valid_in, n_last);
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_reconfig_rules();
        // Two beats into the current image: reconfiguration is refused.
        cfg_start = 1'b1;
        #1;
        vectors++;
        if (x_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midimg_x_ready: got %b want 1", x_ready);
        end
        step();
        cfg_start = 1'b0;
        vectors++;
        if (cfg_err !== 1'b1 || configured !== 1'b1) begin
            miscompares++;
            $display("FAIL midimg_cfg_err: got err=%b cfgd=%b want err=1 cfgd=1", cfg_err, configured);
        end
        step();
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midimg_cfg_err_pulse: got %b want 0", cfg_err);
        end
        for (int k = 0; k < 2; k++) begin
            x_valid = 1'b1;
            x_data  = 16'(16'hD000 + k);
            step();
            vectors++;
            if (n_valid_in !== 1'b1 || n_w !== wexp[bidx] || n_last !== (bidx == 3)) begin
                miscompares++;
                $display("FAIL finish_img[%0d]: got v=%b w=%h l=%b want v=1 w=%h l=%b",
                         k, n_valid_in, n_w, n_last, wexp[bidx], (bidx == 3));
            end
            bidx = (bidx + 1) % 4;
        end
        // Image boundary: reconfiguration accepted and the offered beat is refused.
        cfg_start = 1'b1;
        x_data    = 16'hEEEE;
        #1;
        vectors++;
        if (x_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_x_ready: got %b want 0", x_ready);
        end
        step();
        cfg_start = 1'b0;
        vectors++;
        if (n_valid_in !== 1'b0 || configured !== 1'b0 || cfg_err !== 1'b0 || n_x !== 16'hD001) begin
            miscompares++;
            $display("FAIL boundary_accept: got v=%b cfgd=%b err=%b x=%h want 0 0 0 d001",
                     n_valid_in, configured, cfg_err, n_x);
        end
        wexp[0] = 16'd1; wexp[1] = 16'd2; wexp[2] = 16'd3; wexp[3] = 16'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (x_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL recfg_x_ready[%0d]: got %b want 0", i, x_ready);
            end
            write_word((i == 0) ? 16'd3 : wexp[i-1]);
            vectors++;
            if (n_valid_in !== 1'b0) begin
                miscompares++;
                $display("FAIL recfg_n_valid[%0d]: got %b want 0", i, n_valid_in);
            end
        end
        x_valid = 1'b0;
        vectors++;
        if (configured !== 1'b1 || cfg_done !== 1'b1 || n_threshold !== 16'd3) begin
            miscompares++;
            $display("FAIL recfg_done: got cfgd=%b done=%b thr=%h want 1 1 0003", configured, cfg_done, n_threshold);
        end
        bidx = 0;
    endtask

    task automatic test_async_reset();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        write_word(16'd5);
        write_word(16'h1234);
        write_word(16'h5678);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({n_x, n_w, n_threshold, n_valid_in, n_last, configured, cfg_done, cfg_err, x_ready} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got x=%h w=%h thr=%h v=%b l=%b cfgd=%b done=%b err=%b rdy=%b, want all 0",
                     n_x, n_w, n_threshold, n_valid_in, n_last, configured, cfg_done, cfg_err, x_ready);
        end
        step();
        rst = 1'b0;
        step();
        // A word without cfg_start in UNCFG must be ignored.
        write_word(16'h00FF);
        vectors++;
        if (n_threshold !== 16'd0 || configured !== 1'b0) begin
            miscompares++;
            $display("FAIL uncfg_word_ignored: got thr=%h cfgd=%b want 0000 0", n_threshold, configured);
        end
        wexp[0] = 16'h0101; wexp[1] = 16'h0202; wexp[2] = 16'h0303; wexp[3] = 16'h0404;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        write_word(16'd7);
        for (int i = 0; i < 4; i++) write_word(wexp[i]);
        vectors++;
        if (configured !== 1'b1 || cfg_done !== 1'b1 || n_threshold !== 16'd7) begin
            miscompares++;
            $display("FAIL post_reset_cfg: got cfgd=%b done=%b thr=%h want 1 1 0007", configured, cfg_done, n_threshold);
        end
        for (int k = 0; k < 4; k++) begin
            x_valid = 1'b1;
            x_data  = 16'(16'hA0A0 + k);
            step();
            vectors++;
            if (n_valid_in !== 1'b1 || n_x !== 16'(16'hA0A0 + k) || n_w !== wexp[k] || n_last !== (k == 3)) begin
                miscompares++;
                $display("FAIL post_reset_beat[%0d]: got v=%b x=%h w=%h l=%b want v=1 x=%h w=%h l=%b",
                         k, n_valid_in, n_x, n_w, n_last, 16'(16'hA0A0 + k), wexp[k], (k == 3));
            end
        end
        x_valid = 1'b0;
        step();
        vectors++;
        if (n_valid_in !== 1'b0 || n_last !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got v=%b l=%b want 0 0", n_valid_in, n_last);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bidx        = 0;
        test_reset();
        test_config();
        test_back_to_back();
        test_gapped();
        test_reconfig_rules();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
